// File: rtl/mips_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters, circular
// return-address stack, and saturating branch/mispredict statistics.
module mips_branch_predictor #(
    parameter int WL        = 32,
    parameter int ENTRIES   = 16,
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WL-1:0]    pc_if,
    output logic             pred_taken,
    output logic [WL-1:0]    pred_next_pc,
    input  logic             upd_valid,
    input  logic [WL-1:0]    upd_pc,
    input  logic [1:0]       upd_kind,
    input  logic             upd_taken,
    input  logic [WL-1:0]    upd_target,
    input  logic             upd_pred_taken,
    input  logic [WL-1:0]    upd_pred_pc,
    output logic             mispredict,
    output logic [WL-1:0]    redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WL - IDX_W - 2;
    localparam int RAS_W = $clog2(RAS_DEPTH);

    localparam logic [1:0] K_BR  = 2'b00;
    localparam logic [1:0] K_CAL = 2'b10;
    localparam logic [1:0] K_RET = 2'b11;

    logic             r_valid  [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [WL-1:0]    r_target [ENTRIES];
    logic [1:0]       r_kind   [ENTRIES];

    logic [WL-1:0]    r_ras [RAS_DEPTH];
    logic [RAS_W-1:0] r_ras_top;
    logic [RAS_W:0]   r_ras_cnt;

    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_miss_count;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [WL-1:0]    w_pc_if_inc;

    logic             w_upd_en;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [WL-1:0]    w_upd_pc_inc;
    logic [1:0]       w_ctr_next;
    logic             w_ras_empty;
    logic             w_ras_full;
    logic [RAS_W-1:0] w_ras_push_slot;
    logic             w_mispredict;

    // Lookup path: purely combinational from registered state, no update bypass.
    assign w_lk_idx    = pc_if[IDX_W+1:2];
    assign w_lk_tag    = pc_if[WL-1:IDX_W+2];
    assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_pc_if_inc = pc_if + WL'(4);
    assign w_ras_empty = (r_ras_cnt == '0);
    assign w_ras_full  = (r_ras_cnt == (RAS_W+1)'(RAS_DEPTH));

    always_comb begin
        pred_taken   = 1'b0;
        pred_next_pc = w_pc_if_inc;
        if (w_lk_hit) begin
            case (r_kind[w_lk_idx])
                K_BR: begin
                    if (r_ctr[w_lk_idx][1]) begin
                        pred_taken   = 1'b1;
                        pred_next_pc = r_target[w_lk_idx];
                    end
                end
                K_RET: begin
                    if (!w_ras_empty) begin
                        pred_taken   = 1'b1;
                        pred_next_pc = r_ras[r_ras_top];
                    end
                end
                default: begin
                    pred_taken   = 1'b1;
                    pred_next_pc = r_target[w_lk_idx];
                end
            endcase
        end
    end

    assign w_upd_en     = upd_valid && !clr;
    assign w_up_idx     = upd_pc[IDX_W+1:2];
    assign w_up_tag     = upd_pc[WL-1:IDX_W+2];
    assign w_up_hit     = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_upd_pc_inc = upd_pc + WL'(4);

    always_comb begin
        w_ctr_next = r_ctr[w_up_idx];
        if (!w_up_hit) begin
            w_ctr_next = upd_taken ? 2'b10 : 2'b01;
        end else if (upd_taken) begin
            if (r_ctr[w_up_idx] != 2'b11) w_ctr_next = r_ctr[w_up_idx] + 2'b01;
        end else begin
            if (r_ctr[w_up_idx] != 2'b00) w_ctr_next = r_ctr[w_up_idx] - 2'b01;
        end
        if (upd_kind != K_BR) w_ctr_next = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (w_upd_en) begin
            r_valid[w_up_idx] <= 1'b1;
            r_ctr[w_up_idx]   <= w_ctr_next;
        end
    end

    // Not-taken hits keep the old target so a loop exit does not lose it.
    always_ff @(posedge clk) begin
        if (w_upd_en) begin
            r_tag[w_up_idx]  <= w_up_tag;
            r_kind[w_up_idx] <= upd_kind;
            if (!w_up_hit || upd_taken) r_target[w_up_idx] <= upd_target;
        end
    end

    assign w_ras_push_slot = r_ras_top + RAS_W'(1);

    // A push onto a full stack lands on the oldest slot since the buffer is circular.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_ras_top <= '0;
            r_ras_cnt <= '0;
        end else if (w_upd_en && upd_kind == K_CAL) begin
            r_ras_top <= w_ras_push_slot;
            if (!w_ras_full) r_ras_cnt <= r_ras_cnt + (RAS_W+1)'(1);
        end else if (w_upd_en && upd_kind == K_RET && !w_ras_empty) begin
            r_ras_top <= r_ras_top - RAS_W'(1);
            r_ras_cnt <= r_ras_cnt - (RAS_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_upd_en && upd_kind == K_CAL) r_ras[w_ras_push_slot] <= w_upd_pc_inc;
    end

    assign redirect_pc  = upd_taken ? upd_target : w_upd_pc_inc;
    assign w_mispredict = w_upd_en &&
                          ((upd_pred_taken != upd_taken) || (upd_pred_pc != redirect_pc));
    assign mispredict   = w_mispredict;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_upd_en && r_br_count != '1)     r_br_count   <= r_br_count + CNT_W'(1);
            if (w_mispredict && r_miss_count != '1) r_miss_count <= r_miss_count + CNT_W'(1);
        end
    end

    assign br_count   = r_br_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Directed plus randomized bench for mips_branch_predictor against a behavioural
// model (word-address BTB entries, queue-based return stack).
module tb_mips_branch_predictor;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] pc_if = '0;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [1:0]  upd_kind = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_pc = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  br_count;
    logic [3:0]  miss_count;

    mips_branch_predictor #(.WL(32), .ENTRIES(16), .RAS_DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .clr(clr), .pc_if(pc_if),
        .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_kind(upd_kind),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_count(br_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          v;
        logic [29:0] wpc;
        logic [31:0] tgt;
        int          ctr;
        logic [1:0]  kind;
    } ent_t;

    ent_t        m_btb[16];
    logic [31:0] m_ras[$];
    int          m_br, m_miss;
    bit          m_known = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        foreach (m_btb[i]) begin
            m_btb[i].v   = 0;
            m_btb[i].ctr = 1;
        end
        m_ras.delete();
        m_br   = 0;
        m_miss = 0;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = int'(pc[31:2] % 16);
        return m_btb[i].v && (m_btb[i].wpc == pc[31:2]);
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output bit tk, output logic [31:0] np);
        int i = int'(pc[31:2] % 16);
        tk = 0;
        np = pc + 32'd4;
        if (m_hit(pc)) begin
            if (m_btb[i].kind == 2'b00) begin
                if (m_btb[i].ctr >= 2) begin tk = 1; np = m_btb[i].tgt; end
            end else if (m_btb[i].kind == 2'b11) begin
                if (m_ras.size() > 0) begin tk = 1; np = m_ras[$]; end
            end else begin
                tk = 1;
                np = m_btb[i].tgt;
            end
        end
    endfunction

    function automatic void m_update(input logic [31:0] pc, input logic [1:0] kd, input bit tk,
                                     input logic [31:0] tg, input bit mp);
        int i = int'(pc[31:2] % 16);
        if (m_br < 15) m_br++;
        if (mp && m_miss < 15) m_miss++;
        if (!m_hit(pc)) begin
            m_btb[i].ctr = tk ? 2 : 1;
            m_btb[i].tgt = tg;
        end else if (tk) begin
            m_btb[i].ctr = (m_btb[i].ctr < 3) ? m_btb[i].ctr + 1 : 3;
            m_btb[i].tgt = tg;
        end else begin
            m_btb[i].ctr = (m_btb[i].ctr > 0) ? m_btb[i].ctr - 1 : 0;
        end
        if (kd != 2'b00) m_btb[i].ctr = 3;
        m_btb[i].v    = 1;
        m_btb[i].wpc  = pc[31:2];
        m_btb[i].kind = kd;
        if (kd == 2'b10) begin
            m_ras.push_back(pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
        end else if (kd == 2'b11 && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
    endfunction

    task automatic do_cycle(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                            input logic [1:0] kd, input bit tk, input logic [31:0] tg,
                            input bit ptk, input logic [31:0] ppc, input bit rst);
        bit          e_tk;
        logic [31:0] e_np, e_rd;
        bit          e_mp;
        @(posedge clk);
        #1;
        pc_if = lpc; upd_valid = uv; upd_pc = upc; upd_kind = kd; upd_taken = tk;
        upd_target = tg; upd_pred_taken = ptk; upd_pred_pc = ppc; clr = rst;
        @(negedge clk);
        e_rd = tk ? tg : upc + 32'd4;
        e_mp = uv && ((ptk != tk) || (ppc != e_rd));
        if (m_known) begin
            m_predict(lpc, e_tk, e_np);
            chk("pred_taken", 32'(pred_taken), 32'(e_tk));
            chk("pred_next_pc", pred_next_pc, e_np);
            chk("br_count", 32'(br_count), 32'(m_br));
            chk("miss_count", 32'(miss_count), 32'(m_miss));
            if (!rst) begin
                chk("mispredict", 32'(mispredict), 32'(e_mp));
                if (uv) chk("redirect_pc", redirect_pc, e_rd);
            end
        end
        if (rst) begin
            m_reset();
            m_known = 1;
        end else if (uv) begin
            m_update(upc, kd, tk, tg, e_mp);
        end
    endtask

    task automatic idle(input logic [31:0] lpc);
        do_cycle(lpc, 0, 32'h0, 2'b00, 0, 32'h0, 0, 32'h0, 0);
    endtask

    // Resolve an instruction whose carried prediction matches what the model predicts.
    task automatic train(input logic [31:0] pc, input logic [1:0] kd, input bit tk, input logic [31:0] tg);
        bit          ptk;
        logic [31:0] ppc;
        m_predict(pc, ptk, ppc);
        do_cycle(pc, 1, pc, kd, tk, tg, ptk, ppc, 0);
    endtask

    logic [31:0] pool[8] = '{32'h40, 32'h80, 32'h1004, 32'h200, 32'hC0, 32'h10, 32'h2040, 32'h44};
    logic [31:0] ras_exp[4] = '{32'h54, 32'h44, 32'h34, 32'h24};

    initial begin
        int miss_before;
        do_cycle(32'h40, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(32'h40);
        chk("reset_taken", 32'(pred_taken), 32'h0);
        chk("reset_next", pred_next_pc, 32'h44);
        chk("reset_br", 32'(br_count), 32'h0);
        chk("reset_miss", 32'(miss_count), 32'h0);

        do_cycle(32'h40, 1, 32'h40, 2'b00, 1, 32'h100, 0, 32'h44, 0);
        idle(32'h40);
        chk("trained_taken", 32'(pred_taken), 32'h1);
        chk("trained_next", pred_next_pc, 32'h100);
        train(32'h40, 2'b00, 0, 32'h100);
        train(32'h40, 2'b00, 0, 32'h100);
        idle(32'h40);
        chk("ctr00_next", pred_next_pc, 32'h44);
        train(32'h40, 2'b00, 1, 32'h100);
        idle(32'h40);
        chk("ctr01_taken", 32'(pred_taken), 32'h0);
        train(32'h40, 2'b00, 1, 32'h100);
        train(32'h40, 2'b00, 1, 32'h100);
        train(32'h40, 2'b00, 0, 32'h100);
        idle(32'h40);
        chk("ctr11_dec_taken", 32'(pred_taken), 32'h1);
        chk("ctr11_dec_next", pred_next_pc, 32'h100);

        train(32'h80, 2'b00, 1, 32'h180);
        idle(32'h40);
        chk("alias_evicted", pred_next_pc, 32'h44);
        idle(32'h80);
        chk("alias_new_next", pred_next_pc, 32'h180);

        train(32'h1004, 2'b11, 1, 32'h0);
        idle(32'h1004);
        chk("ret_empty_taken", 32'(pred_taken), 32'h0);
        for (int k = 1; k <= 5; k++) train(32'(k * 16), 2'b10, 1, 32'h500);
        for (int k = 0; k < 4; k++) begin
            train(32'h1004, 2'b11, 1, ras_exp[k]);
            chk("ras_pop_next", pred_next_pc, ras_exp[k]);
        end
        idle(32'h1004);
        chk("ras_drained_taken", 32'(pred_taken), 32'h0);

        do_cycle(32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(32'h0);
        miss_before = int'(miss_count);
        do_cycle(32'h200, 1, 32'h200, 2'b00, 1, 32'h300, 0, 32'h204, 0);
        chk("mp_flag", 32'(mispredict), 32'h1);
        chk("mp_redirect", redirect_pc, 32'h300);
        idle(32'h0);
        chk("mp_miss_inc", 32'(miss_count), 32'(miss_before + 1));
        do_cycle(32'h0, 1, 32'h200, 2'b00, 1, 32'h300, 1, 32'h300, 0);
        chk("ok_pred_no_mp", 32'(mispredict), 32'h0);

        for (int k = 0; k < 20; k++) do_cycle(32'h0, 1, 32'h600, 2'b00, 1, 32'h700, 0, 32'h604, 0);
        idle(32'h0);
        chk("sat_br", 32'(br_count), 32'hF);
        chk("sat_miss", 32'(miss_count), 32'hF);
        do_cycle(32'h40, 1, 32'h600, 2'b00, 1, 32'h700, 0, 32'h604, 1);
        idle(32'h600);
        chk("clr_btb_empty", 32'(pred_taken), 32'h0);
        chk("clr_br", 32'(br_count), 32'h0);
        chk("clr_miss", 32'(miss_count), 32'h0);

        for (int n = 0; n < 500; n++) begin
            logic [31:0] upc, tg, ppc;
            logic [1:0]  kd;
            bit          tk, ptk, uv, rst;
            upc = pool[$urandom_range(7)];
            kd  = 2'($urandom_range(3));
            tk  = (kd == 2'b00) ? bit'($urandom_range(1)) : 1'b1;
            tg  = pool[$urandom_range(7)] + 32'h1000;
            uv  = ($urandom_range(3) != 0);
            rst = ($urandom_range(49) == 0);
            if ($urandom_range(1) == 1) m_predict(upc, ptk, ppc);
            else begin
                ptk = bit'($urandom_range(1));
                ppc = pool[$urandom_range(7)];
            end
            do_cycle(pool[$urandom_range(7)], uv, upc, kd, tk, tg, ptk, ppc, rst);
        end
        idle(32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
